cache_control: RTL and testbench

Sequencing FSM for the 2-way set-associative data cache datapath. It sits between the CPU-side bus adapter, the cache datapath, and physical memory. It turns hit/valid/dirty/LRU status into array load strobes, byte write enables, fill and writeback handshakes, and the CPU response. It also keeps hit and miss counters for performance bring-up.

---
 rtl/cache_control.sv | 140 ++++++++++++++
 tb/tb_cache_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// cache_control: miss/fill/writeback sequencer for the 2-way set-associative
// data cache. Strobes are combinational from state and inputs; state, victim
// way, fill marker and the hit/miss performance counters are registered.
module cache_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_byte_enable256,
  input  logic [1:0]  hit_datapath,
  input  logic [1:0]  valid_out,
  input  logic [1:0]  dirty_out,
  input  logic        lru_output,
  input  logic        pmem_resp,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic        mem_enable_sel,
  output logic [31:0] write_enable_0,
  output logic [31:0] write_enable_1,
  output logic        load_lru,
  output logic        set_lru,
  output logic [1:0]  load_valid,
  output logic [1:0]  set_valid,
  output logic [1:0]  load_dirty,
  output logic [1:0]  set_dirty,
  output logic [1:0]  load_tag,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2
  } state_t;

  state_t state, next_state;
  logic   victim_q, victim_d;
  logic   fill_q, fill_d;
  logic   hit_inc, miss_inc;
  logic   hit_way;
  logic   req;

  assign req = mem_read | mem_write;

  // State, victim way, fill marker and performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_COMPARE;
      victim_q   <= 1'b0;
      fill_q     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state    <= next_state;
      victim_q <= victim_d;
      fill_q   <= fill_d;
      if (hit_inc)  hit_count  <= hit_count  + CNT_W'(1);
      if (miss_inc) miss_count <= miss_count + CNT_W'(1);
    end
  end

  // Next-state and strobe decode; everything held at 0 while in reset
  always_comb begin
    next_state     = state;
    victim_d       = victim_q;
    fill_d         = fill_q;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    hit_way        = 1'b0;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    mem_enable_sel = 1'b0;
    write_enable_0 = '0;
    write_enable_1 = '0;
    load_lru       = 1'b0;
    set_lru        = 1'b0;
    load_valid     = '0;
    set_valid      = '0;
    load_dirty     = '0;
    set_dirty      = '0;
    load_tag       = '0;
    if (rst) begin
      unique case (state)
        S_COMPARE: begin
          // The replay after a fill is consumed whether or not the CPU waited
          fill_d = 1'b0;
          if (req) begin
            if (|hit_datapath) begin
              hit_way  = ~hit_datapath[0];
              mem_resp = 1'b1;
              load_lru = 1'b1;
              set_lru  = ~hit_way;
              hit_inc  = ~fill_q;
              if (mem_write) begin
                if (hit_way) write_enable_1 = mem_byte_enable256;
                else         write_enable_0 = mem_byte_enable256;
                load_dirty[hit_way] = 1'b1;
                set_dirty[hit_way]  = 1'b1;
              end
            end else begin
              victim_d   = lru_output;
              miss_inc   = 1'b1;
              next_state = (valid_out[lru_output] & dirty_out[lru_output])
                           ? S_WRITEBACK : S_FETCH;
            end
          end
        end
        S_WRITEBACK: begin
          pmem_write = 1'b1;
          if (pmem_resp) begin
            load_dirty[victim_q] = 1'b1;
            next_state           = S_FETCH;
          end
        end
        S_FETCH: begin
          pmem_read      = 1'b1;
          mem_enable_sel = 1'b1;
          if (pmem_resp) begin
            if (victim_q) write_enable_1 = {LINE_BYTES{1'b1}};
            else          write_enable_0 = {LINE_BYTES{1'b1}};
            load_tag[victim_q]   = 1'b1;
            load_valid[victim_q] = 1'b1;
            set_valid[victim_q]  = 1'b1;
            load_dirty[victim_q] = 1'b1;
            fill_d               = 1'b1;
            next_state           = S_COMPARE;
          end
        end
        default: next_state = S_COMPARE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: the bench plays the datapath and memory,
// driving hit/valid/dirty/LRU status by hand and checking strobes and counters.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_byte_enable256;
  logic [1:0]  hit_datapath, valid_out, dirty_out;
  logic        lru_output, pmem_resp;
  logic        mem_resp, pmem_read, pmem_write, mem_enable_sel;
  logic [31:0] write_enable_0, write_enable_1;
  logic        load_lru, set_lru;
  logic [1:0]  load_valid, set_valid, load_dirty, set_dirty, load_tag;
  logic [15:0] hit_count, miss_count;

  int tests = 0;
  int fails = 0;

  cache_control dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256),
    .hit_datapath(hit_datapath), .valid_out(valid_out), .dirty_out(dirty_out),
    .lru_output(lru_output), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .mem_enable_sel(mem_enable_sel),
    .write_enable_0(write_enable_0), .write_enable_1(write_enable_1),
    .load_lru(load_lru), .set_lru(set_lru),
    .load_valid(load_valid), .set_valid(set_valid),
    .load_dirty(load_dirty), .set_dirty(set_dirty),
    .load_tag(load_tag),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs then change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] hit,
                       input logic [1:0] vld, input logic [1:0] drt, input logic lru);
    mem_read = rd; mem_write = wr; hit_datapath = hit;
    valid_out = vld; dirty_out = drt; lru_output = lru;
    #1;
  endtask

  initial begin
    rst = 1'b0; pmem_resp = 1'b0; mem_byte_enable256 = 32'h0;
    drive(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
    // Reset: outputs held at 0 even with a hitting request present
    chk("rst_mem_resp", 32'(mem_resp), 32'h0);
    chk("rst_load_lru", 32'(load_lru), 32'h0);
    chk("rst_hit_count", 32'(hit_count), 32'h0);
    chk("rst_miss_count", 32'(miss_count), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    #8 rst = 1'b1;
    tick();

    // Cold read miss, empty cache, victim = way 0 (clean) -> FETCH
    drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("cold_cmp_resp", 32'(mem_resp), 32'h0);
    chk("cold_cmp_pread", 32'(pmem_read), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("cold_fetch_pread", 32'(pmem_read), 32'h1);
      chk("cold_fetch_pwrite", 32'(pmem_write), 32'h0);
      chk("cold_fetch_sel", 32'(mem_enable_sel), 32'h1);
      chk("cold_fetch_we0_idle", write_enable_0, 32'h0);
      tick();
    end
    pmem_resp = 1'b1; #1;
    chk("cold_fill_pread", 32'(pmem_read), 32'h1);
    chk("cold_fill_tag", 32'(load_tag), 32'h1);
    chk("cold_fill_lvalid", 32'(load_valid), 32'h1);
    chk("cold_fill_svalid", 32'(set_valid), 32'h1);
    chk("cold_fill_ldirty", 32'(load_dirty), 32'h1);
    chk("cold_fill_sdirty", 32'(set_dirty), 32'h0);
    chk("cold_fill_we0", write_enable_0, 32'hFFFF_FFFF);
    chk("cold_fill_we1", write_enable_1, 32'h0);
    tick();
    pmem_resp = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
    chk("cold_replay_resp", 32'(mem_resp), 32'h1);
    chk("cold_replay_pread", 32'(pmem_read), 32'h0);
    chk("cold_replay_lru", 32'({load_lru, set_lru}), 32'h3);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1);
    chk("cold_miss_count", 32'(miss_count), 32'h1);
    chk("cold_hit_count", 32'(hit_count), 32'h0);

    // Write hit on way 0, low four bytes
    mem_byte_enable256 = 32'h0000_000F;
    drive(1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 1'b1);
    chk("wh_resp", 32'(mem_resp), 32'h1);
    chk("wh_we0", write_enable_0, 32'h0000_000F);
    chk("wh_we1", write_enable_1, 32'h0);
    chk("wh_sel", 32'(mem_enable_sel), 32'h0);
    chk("wh_dirty", 32'({load_dirty, set_dirty}), 32'h5);
    chk("wh_lru", 32'({load_lru, set_lru}), 32'h3);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1);
    chk("wh_hit_count", 32'(hit_count), 32'h1);

    // Fill way 1 (0x1040): victim invalid -> FETCH, pmem_resp in first cycle
    drive(1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1);
    tick();
    chk("f1_pread", 32'(pmem_read), 32'h1);
    chk("f1_pwrite", 32'(pmem_write), 32'h0);
    pmem_resp = 1'b1; #1;
    chk("f1_tag", 32'(load_tag), 32'h2);
    chk("f1_we1", write_enable_1, 32'hFFFF_FFFF);
    chk("f1_we0", write_enable_0, 32'h0);
    tick();
    pmem_resp = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 2'b11, 2'b01, 1'b1);
    chk("f1_replay_resp", 32'(mem_resp), 32'h1);
    chk("f1_replay_lru", 32'({load_lru, set_lru}), 32'h2);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 1'b0);
    chk("f1_hit_count", 32'(hit_count), 32'h1);

    // Dirty eviction of way 0 (0x2040); lru flips mid-miss, victim must hold
    drive(1'b1, 1'b0, 2'b00, 2'b11, 2'b01, 1'b0);
    tick();
    lru_output = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      chk("ev_wb_pwrite", 32'(pmem_write), 32'h1);
      chk("ev_wb_pread", 32'(pmem_read), 32'h0);
      tick();
    end
    pmem_resp = 1'b1; #1;
    chk("ev_wb_ldirty", 32'(load_dirty), 32'h1);
    chk("ev_wb_sdirty", 32'(set_dirty), 32'h0);
    tick();
    pmem_resp = 1'b0; #1;
    chk("ev_fetch_pread", 32'(pmem_read), 32'h1);
    chk("ev_fetch_pwrite", 32'(pmem_write), 32'h0);
    pmem_resp = 1'b1; #1;
    chk("ev_fetch_tag", 32'(load_tag), 32'h1);
    chk("ev_fetch_we0", write_enable_0, 32'hFFFF_FFFF);
    tick();
    pmem_resp = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1);
    chk("ev_replay_resp", 32'(mem_resp), 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
    chk("ev_miss_count", 32'(miss_count), 32'h3);
    chk("ev_hit_count", 32'(hit_count), 32'h1);

    // pmem_resp while idle in COMPARE is ignored
    pmem_resp = 1'b1; #1;
    chk("idle_resp_tag", 32'(load_tag), 32'h0);
    tick();
    pmem_resp = 1'b0; #1;
    chk("idle_resp_pread", 32'(pmem_read), 32'h0);

    // Dropped request mid-FETCH: fill still installs, no mem_resp afterwards
    drive(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
    chk("drop_pread", 32'(pmem_read), 32'h1);
    tick();
    pmem_resp = 1'b1; #1;
    chk("drop_tag", 32'(load_tag), 32'h2);
    tick();
    pmem_resp = 1'b0; #1;
    chk("drop_idle_resp", 32'(mem_resp), 32'h0);
    chk("drop_idle_pread", 32'(pmem_read), 32'h0);
    tick();
    // fill marker was consumed by the idle cycle, so this hit counts
    drive(1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0);
    chk("drop_next_hit_resp", 32'(mem_resp), 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
    chk("drop_hit_count", 32'(hit_count), 32'h2);
    chk("drop_miss_count", 32'(miss_count), 32'h4);

    // Reset asserted mid-FETCH drops pmem_read at once
    drive(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
    tick();
    chk("rf_pread_before", 32'(pmem_read), 32'h1);
    #2 rst = 1'b0; #1;
    chk("rf_pread_in_rst", 32'(pmem_read), 32'h0);
    chk("rf_hit_count", 32'(hit_count), 32'h0);
    chk("rf_miss_count", 32'(miss_count), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    chk("rf_after_pread", 32'(pmem_read), 32'h0);
    chk("rf_after_pwrite", 32'(pmem_write), 32'h0);

    // Hit counter wrap after 65536 hits
    drive(1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    chk("wrap_ffff", 32'(hit_count), 32'h0000_FFFF);
    tick();
    chk("wrap_zero", 32'(hit_count), 32'h0);
    chk("wrap_miss_count", 32'(miss_count), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
